// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter
//   Round-robin arbiter for a shared snoop bus. One coherence transaction is
//   in flight at a time: grant -> broadcast snoop -> optional dirty-owner
//   write-back -> optional line fill -> one-cycle completion to the requester.
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_type/req_addr      per-core requests (held until req_ready)
//   req_ready                        one-hot grant, combinational in IDLE
//   snoop_valid/type/addr/src        broadcast of the granted transaction
//   snoop_ack/shared/dirty           per-core snoop responses
//   wb_wait / wb_done                dirty owner write-back handshake
//   mem_rd_req/mem_rd_addr/ack       line fill handshake
//   done / done_shared               completion pulse, fill state S vs E/M
//   timeout_err                      pulse when snoop acks time out
module snoop_bus_arbiter #(
  parameter int NUM_CORES     = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int SNOOP_TIMEOUT = 15
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CORES-1:0]                   req_valid,
  input  logic [NUM_CORES-1:0][1:0]              req_type,
  input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0]   req_addr,
  output logic [NUM_CORES-1:0]                   req_ready,
  output logic                                   snoop_valid,
  output logic [1:0]                             snoop_type,
  output logic [ADDR_WIDTH-1:0]                  snoop_addr,
  output logic [$clog2(NUM_CORES)-1:0]           snoop_src,
  input  logic [NUM_CORES-1:0]                   snoop_ack,
  input  logic [NUM_CORES-1:0]                   snoop_shared,
  input  logic [NUM_CORES-1:0]                   snoop_dirty,
  output logic                                   wb_wait,
  input  logic                                   wb_done,
  output logic                                   mem_rd_req,
  output logic [ADDR_WIDTH-1:0]                  mem_rd_addr,
  input  logic                                   mem_rd_ack,
  output logic [NUM_CORES-1:0]                   done,
  output logic                                   done_shared,
  output logic                                   timeout_err
);

  localparam int SRC_W = $clog2(NUM_CORES);

  localparam logic [1:0] T_BUSRD  = 2'b00;
  localparam logic [1:0] T_BUSUPG = 2'b10;
  localparam logic [1:0] T_RSVD   = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_SNOOP, S_WAIT_WB, S_MEM, S_DONE} state_e;

  // Latched transaction
  typedef struct packed {
    logic [1:0]            typ;
    logic [ADDR_WIDTH-1:0] addr;
    logic [SRC_W-1:0]      src;
  } txn_t;

  state_e               state_q, state_d;
  txn_t                 txn_q, txn_d;
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0] acked_q, acked_d;
  logic                 shared_q, shared_d;
  logic                 dirty_q, dirty_d;
  logic [7:0]           cnt_q, cnt_d;

  logic                 grant_vld;
  logic [SRC_W-1:0]     winner;
  logic [SRC_W:0]       cand;
  logic [NUM_CORES-1:0] src_mask, acked_now, resp_mask;
  logic                 all_acked, snoop_to;

  // Circular priority search starting at rr_ptr. Walking offsets from the
  // highest down lets the smallest offset overwrite and win.
  always_comb begin
    grant_vld = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
      if (cand >= (SRC_W+1)'(NUM_CORES)) cand = cand - (SRC_W+1)'(NUM_CORES);
      if (req_valid[cand[SRC_W-1:0]]) begin
        grant_vld = 1'b1;
        winner    = cand[SRC_W-1:0];
      end
    end
  end

  // The requester never snoops itself; its response lines are masked out
  // and it counts as already acked.
  assign src_mask  = NUM_CORES'(1) << txn_q.src;
  assign resp_mask = snoop_ack & ~src_mask;
  assign acked_now = acked_q | resp_mask;
  assign all_acked = &(acked_now | src_mask);

  always_comb begin
    state_d  = state_q;
    txn_d    = txn_q;
    rr_ptr_d = rr_ptr_q;
    acked_d  = acked_q;
    shared_d = shared_q;
    dirty_d  = dirty_q;
    cnt_d    = cnt_q;
    snoop_to = 1'b0;
    case (state_q)
      S_IDLE: if (grant_vld) begin
        state_d   = S_SNOOP;
        // Reserved encoding behaves exactly like BusRd from here on
        txn_d.typ  = (req_type[winner] == T_RSVD) ? T_BUSRD : req_type[winner];
        txn_d.addr = req_addr[winner];
        txn_d.src  = winner;
        rr_ptr_d  = (winner == SRC_W'(NUM_CORES-1)) ? '0 : winner + 1'b1;
        acked_d   = '0;
        shared_d  = 1'b0;
        dirty_d   = 1'b0;
        cnt_d     = '0;
      end
      S_SNOOP: begin
        acked_d  = acked_now;
        shared_d = shared_q | (|(resp_mask & snoop_shared));
        dirty_d  = dirty_q  | (|(resp_mask & snoop_dirty));
        cnt_d    = cnt_q + 8'd1;
        // cnt_q counts completed SNOOP cycles, so TIMEOUT-1 is the last one
        if (all_acked || cnt_q == 8'(SNOOP_TIMEOUT-1)) begin
          snoop_to = !all_acked;
          if (txn_q.typ == T_BUSUPG)  state_d = S_DONE;
          else if (dirty_d)           state_d = S_WAIT_WB;
          else                        state_d = S_MEM;
        end
      end
      S_WAIT_WB: if (wb_done)    state_d = S_MEM;
      S_MEM:     if (mem_rd_ack) state_d = S_DONE;
      S_DONE:                    state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      txn_q    <= '0;
      rr_ptr_q <= '0;
      acked_q  <= '0;
      shared_q <= 1'b0;
      dirty_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      txn_q    <= txn_d;
      rr_ptr_q <= rr_ptr_d;
      acked_q  <= acked_d;
      shared_q <= shared_d;
      dirty_q  <= dirty_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode the registered state; payloads are zeroed outside their state
  assign req_ready   = (state_q == S_IDLE && grant_vld && !rst) ? (NUM_CORES'(1) << winner) : '0;
  assign snoop_valid = (state_q == S_SNOOP);
  assign snoop_type  = snoop_valid ? txn_q.typ  : '0;
  assign snoop_addr  = snoop_valid ? txn_q.addr : '0;
  assign snoop_src   = snoop_valid ? txn_q.src  : '0;
  assign timeout_err = snoop_to;
  assign wb_wait     = (state_q == S_WAIT_WB);
  assign mem_rd_req  = (state_q == S_MEM);
  assign mem_rd_addr = mem_rd_req ? txn_q.addr : '0;
  assign done        = (state_q == S_DONE) ? src_mask : '0;
  assign done_shared = (state_q == S_DONE) && (txn_q.typ == T_BUSRD) && (shared_q || dirty_q);

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
module tb_snoop_bus_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0][1:0]  req_type;
  logic [3:0][31:0] req_addr;
  logic [3:0]       req_ready;
  logic             snoop_valid;
  logic [1:0]       snoop_type;
  logic [31:0]      snoop_addr;
  logic [1:0]       snoop_src;
  logic [3:0]       snoop_ack, snoop_shared, snoop_dirty;
  logic             wb_wait, wb_done;
  logic             mem_rd_req, mem_rd_ack;
  logic [31:0]      mem_rd_addr;
  logic [3:0]       done;
  logic             done_shared, timeout_err;

  int errors = 0;
  int checks = 0;

  snoop_bus_arbiter #(.NUM_CORES(4), .ADDR_WIDTH(32), .SNOOP_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr), .req_ready(req_ready),
    .snoop_valid(snoop_valid), .snoop_type(snoop_type), .snoop_addr(snoop_addr), .snoop_src(snoop_src),
    .snoop_ack(snoop_ack), .snoop_shared(snoop_shared), .snoop_dirty(snoop_dirty),
    .wb_wait(wb_wait), .wb_done(wb_done),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
    .done(done), .done_shared(done_shared), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no summary expected=summary before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain BusRd by the core in exp_grant: everyone else acks clean in the
  // first SNOOP cycle, memory acks in the first MEM cycle.
  task automatic do_rd(input string tag, input logic [3:0] exp_grant);
    #1 chk({tag, "_grant"}, req_ready, exp_grant);
    tick();
    req_valid = req_valid & ~exp_grant;
    snoop_ack = ~exp_grant;
    #1 chk({tag, "_snoop_vld"}, snoop_valid, 1'b1);
    chk({tag, "_ready_busy"}, req_ready, 4'b0000);
    tick();
    snoop_ack  = 4'b0000;
    mem_rd_ack = 1'b1;
    #1 chk({tag, "_mem_req"}, mem_rd_req, 1'b1);
    tick();
    mem_rd_ack = 1'b0;
    #1 chk({tag, "_done"}, done, exp_grant);
    chk({tag, "_no_grant_in_done"}, req_ready, 4'b0000);
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_type = '0; req_addr = '0;
    snoop_ack = '0; snoop_shared = '0; snoop_dirty = '0;
    wb_done = 1'b0; mem_rd_ack = 1'b0;
    tick(); tick();

    // Reset: requests must not be granted while rst is high
    req_valid = 4'b1111;
    #1 chk("rst_ready", req_ready, 4'b0000);
    req_valid = 4'b0000;
    tick();
    rst = 1'b0;
    #1 chk("rst_snoop_valid", snoop_valid, 1'b0);
    chk("rst_done", done, 4'b0000);
    chk("rst_misc", {wb_wait, mem_rd_req, timeout_err, done_shared}, 4'b0000);

    // Core 2 BusRd 0x100, clean acks; its own shared response is ignored
    req_valid = 4'b0100; req_addr[2] = 32'h100;
    #1 chk("t1_grant", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    snoop_ack = 4'b1111; snoop_shared = 4'b0100;
    #1 chk("t1_snoop_src", snoop_src, 2'd2);
    chk("t1_snoop_addr", snoop_addr, 32'h100);
    chk("t1_snoop_type", snoop_type, 2'b00);
    tick();
    snoop_ack = '0; snoop_shared = '0;
    #1 chk("t1_mem_addr", mem_rd_addr, 32'h100);
    tick(); tick();
    mem_rd_ack = 1'b1;
    #1 chk("t1_mem_still", mem_rd_req, 1'b1);
    tick();
    mem_rd_ack = 1'b0;
    #1 chk("t1_done", done, 4'b0100);
    chk("t1_done_shared", done_shared, 1'b0);
    tick();
    #1 chk("t1_done_pulse", done, 4'b0000);

    // Round robin after reset: 0, then 1 beats a re-requesting 0, then 3, then 0
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b1011;
    do_rd("rr0", 4'b0001);
    req_valid = req_valid | 4'b0001;
    do_rd("rr1", 4'b0010);
    do_rd("rr3", 4'b1000);
    do_rd("rr0b", 4'b0001);

    // Core 0 BusRd, core 3 dirty: write-back first; stray mem ack ignored
    req_valid = 4'b0001; req_addr[0] = 32'h200;
    #1 chk("t3_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0; snoop_ack = 4'b1110; snoop_dirty = 4'b1000;
    tick();
    snoop_ack = '0; snoop_dirty = '0; mem_rd_ack = 1'b1;
    #1 chk("t3_wb_wait", wb_wait, 1'b1);
    chk("t3_no_mem", mem_rd_req, 1'b0);
    tick();
    mem_rd_ack = 1'b0;
    #1 chk("t3_wb_hold", wb_wait, 1'b1);
    wb_done = 1'b1;
    tick();
    wb_done = 1'b0;
    #1 chk("t3_wb_clear", wb_wait, 1'b0);
    chk("t3_mem_addr", {mem_rd_req, mem_rd_addr}, {1'b1, 32'h200});
    mem_rd_ack = 1'b1;
    tick();
    mem_rd_ack = 1'b0;
    #1 chk("t3_done", {done, done_shared}, {4'b0001, 1'b1});
    tick();

    // Core 1 BusUpgr, core 2 dirty+shared: straight to DONE
    req_valid = 4'b0010; req_type[1] = 2'b10; req_addr[1] = 32'h300;
    #1 chk("t4_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0; snoop_ack = 4'b1101; snoop_dirty = 4'b0100; snoop_shared = 4'b0100;
    #1 chk("t4_snoop_type", snoop_type, 2'b10);
    tick();
    snoop_ack = '0; snoop_dirty = '0; snoop_shared = '0; req_type[1] = 2'b00;
    #1 chk("t4_no_wb_mem", {wb_wait, mem_rd_req}, 2'b00);
    chk("t4_done", {done, done_shared}, {4'b0010, 1'b0});
    tick();

    // Core 0 BusRdX, core 3 silent: timeout on the 15th SNOOP cycle
    req_valid = 4'b0001; req_type[0] = 2'b01;
    #1 chk("t5_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0; snoop_ack = 4'b0110;
    #1 chk("t5_to_c1", timeout_err, 1'b0);
    tick();
    snoop_ack = '0;
    repeat (12) tick();
    #1 chk("t5_to_c14", {snoop_valid, timeout_err}, 2'b10);
    tick();
    #1 chk("t5_to_c15", {snoop_valid, timeout_err}, 2'b11);
    tick();
    #1 chk("t5_mem", {timeout_err, mem_rd_req}, 2'b01);
    mem_rd_ack = 1'b1;
    tick();
    mem_rd_ack = 1'b0; req_type[0] = 2'b00;
    #1 chk("t5_done", {done, done_shared}, {4'b0001, 1'b0});
    tick();

    // Reset while in MEM: no done, rr_ptr back to 0
    req_valid = 4'b0010;
    #1 chk("t6_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0; snoop_ack = 4'b1101;
    tick();
    snoop_ack = '0;
    #1 chk("t6_in_mem", mem_rd_req, 1'b1);
    rst = 1'b1; mem_rd_ack = 1'b1;
    tick();
    rst = 1'b0; mem_rd_ack = 1'b0;
    #1 chk("t6_outs_zero", {mem_rd_req, wb_wait, snoop_valid, timeout_err, done_shared}, 5'b0);
    chk("t6_no_done", done, 4'b0000);
    tick();
    #1 chk("t6_no_done2", done, 4'b0000);
    req_valid = 4'b1001;
    do_rd("t6_after", 4'b0001);

    // Reserved type from core 3 behaves as BusRd with shared fill
    req_valid = 4'b1000; req_type[3] = 2'b11;
    #1 chk("t7_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0; snoop_ack = 4'b0111; snoop_shared = 4'b0010;
    #1 chk("t7_snoop_type", snoop_type, 2'b00);
    tick();
    snoop_ack = '0; snoop_shared = '0; mem_rd_ack = 1'b1;
    tick();
    mem_rd_ack = 1'b0;
    #1 chk("t7_done", {done, done_shared}, {4'b1000, 1'b1});
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
